// File: rtl/logic_accum_pkg.sv
// logic_accum_pkg: shared types for the logic_accum reduce block.
//   op_e    - reduce operation encoding carried on the op port
//   state_e - packet FSM states
package logic_accum_pkg;

  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_XOR  = 2'b10,
    OP_NAND = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,  // no beat of the current packet accepted yet
    ACC  = 2'b01,  // accumulating, last beat not yet seen
    DONE = 2'b10   // result held on the output until taken
  } state_e;

endpackage

// File: rtl/logic_op_unit.sv
// logic_op_unit: purely combinational two-operand bitwise combine.
//   op - reduce operation (NAND combines as AND; the final inversion
//        is applied once on the result, not per beat)
//   a  - running accumulator
//   b  - incoming word
//   y  - combined word
module logic_op_unit
  import logic_accum_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  op_e              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NAND: y = a & b;
      default: y = a & b;
    endcase
  end

endmodule

// File: rtl/logic_accum.sv
// logic_accum: reduces the words of a packet with a bitwise operation.
//
// Handshake: each side is strict valid/ready. A beat moves on a rising
// clk edge where in_valid && in_ready; a result moves where
// out_valid && out_ready. A presented result and its fields stay
// stable until taken, and in_ready never depends on in_valid.
//
// Ports:
//   clk        - clock, rising edge
//   rst_n      - asynchronous active-low reset
//   op         - reduce op, sampled on the first beat of a packet only
//   in_valid   - input beat offered
//   in_ready   - input beat accepted (high in IDLE and ACC)
//   in_data    - input word
//   in_last    - final beat of the packet
//   out_valid  - result presented (high exactly in DONE)
//   out_ready  - consumer takes the result
//   out_data   - reduced word (inverted for NAND), 0 outside DONE
//   out_count  - beats in the packet, saturating, 0 outside DONE
//   out_ovf    - beat count saturated, 0 outside DONE
//
// The FSM state is held in state_q (type state_e) for observation.
module logic_accum
  import logic_accum_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       op,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  state_e             state_q, state_d;
  op_e                op_q,    op_d;
  logic [WIDTH-1:0]   acc_q,   acc_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic               ovf_q,   ovf_d;

  logic               in_beat;
  logic               out_xfer;
  logic [WIDTH-1:0]   comb_y;

  logic_op_unit #(
    .WIDTH (WIDTH)
  ) u_op (
    .op (op_q),
    .a  (acc_q),
    .b  (in_data),
    .y  (comb_y)
  );

  assign in_ready = (state_q != DONE);
  assign in_beat  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= OP_AND;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_beat) begin
          // First beat: the op is frozen for the whole packet here.
          op_d    = op_e'(op);
          acc_d   = in_data;
          cnt_d   = CNT_W'(1);
          ovf_d   = 1'b0;
          state_d = in_last ? DONE : ACC;
        end
      end
      ACC: begin
        if (in_beat) begin
          acc_d = comb_y;
          if (cnt_q == {CNT_W{1'b1}}) begin
            ovf_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
          if (in_last) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        // No beat is accepted on the transfer cycle, so every packet
        // sees one idle cycle before its first beat can land.
        if (out_xfer) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    out_count = '0;
    out_ovf   = 1'b0;
    if (state_q == DONE) begin
      out_valid = 1'b1;
      out_data  = (op_q == OP_NAND) ? ~acc_q : acc_q;
      out_count = cnt_q;
      out_ovf   = ovf_q;
    end
  end

endmodule
